// File: rtl/pipeline_ctrl.sv
// Pipeline latch/PC enable, flush and forwarding control with load-use stall and sticky halt.
// Stall and flush cycle counters feed the per-core performance registers.
//
// state    | meaning
// RUN      | normal issue, load-use detection armed
// LU_STALL | one bubble inserted, a repeated 011 code is ignored
// HALTED   | core halted, everything disabled until reset
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [2:0]       src1_hazard_t,
    input  logic [2:0]       src2_hazard_t,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             branch_taken,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        HALTED   = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic   freeze;
    logic   lu_req;

    function automatic logic [1:0] fwd_decode(input logic [2:0] code);
        case (code)
            3'b001:  return 2'b01;
            3'b010:  return 2'b10;
            3'b100:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    assign freeze = dmem_req & ~dhit;
    assign lu_req = (state == RUN) &&
                    ((src1_hazard_t == 3'b011) || (src2_hazard_t == 3'b011));
    assign halt   = (state == HALTED);

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        fwd_a_sel   = 2'b00;
        fwd_b_sel   = 2'b00;
        state_nxt   = state;
        if (nRST) begin
            fwd_a_sel = fwd_decode(src1_hazard_t);
            fwd_b_sel = fwd_decode(src2_hazard_t);
            if (state == HALTED || freeze) begin
                state_nxt = state;
            end else if (halt_mem) begin
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                state_nxt = HALTED;
            end else if (branch_taken) begin
                // Branch squashes the younger instructions, so a pending load-use is moot.
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                state_nxt   = RUN;
            end else if (lu_req) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                state_nxt   = LU_STALL;
            end else if (!ihit) begin
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                state_nxt   = RUN;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
                state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state != HALTED && !pc_en) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control stage that directly consumes the forwarding/hazard codes produced by the hazard unit, together with cache hit and branch/halt status. It drives the IF/ID, ID/EX, EX/MEM and MEM/WB latch enables and flushes, the PC enable and the two ALU forwarding mux selects. A small FSM handles one-bubble load-use stalls and the sticky halt. Free-running counters record stall and flush cycles for the per-core performance registers.

## Interface
- CNT_W, 16, width of the performance counters (wrap, no saturation)
- CLK  in  1  core clock, rising edge
- nRST  in  1  asynchronous, active-low reset
- src1_hazard_t  in  3  rs hazard code: 000 none, 001 fwd EX/MEM ALU, 010 fwd MEM/WB ALU, 011 load in EX/MEM (load-use), 100 load in MEM/WB
- src2_hazard_t  in  3  rt hazard code, same encoding
- ihit  in  1  instruction cache hit this cycle
- dhit  in  1  data cache hit this cycle
- dmem_req  in  1  MEM-stage instruction is a load or store
- branch_taken  in  1  taken branch or jump resolved in MEM stage
- halt_mem  in  1  HALT instruction is in MEM stage
- pc_en  out  1  PC register load enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline latch enables
- if_id_flush, id_ex_flush  out  1 each  load NOP into the latch on its enable
- fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 EX/MEM ALU, 10 MEM/WB ALU, 11 MEM/WB load data
- halt  out  1  sticky core-halted flag
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted
- flush_cnt  out  CNT_W  cycles with if_id_flush=1

## Operation
- FSM states: RUN, LU_STALL, HALTED. Reset state is RUN.
- All outputs are combinational from the state and the current inputs. Rules are applied in priority order; the first rule that matches wins:
  1. HALTED: all enables and flushes are 0. halt=1.
  2. Memory freeze (dmem_req & ~dhit): all enables and flushes are 0. State holds.
  3. halt_mem: ex_mem_en=1 and mem_wb_en=1. All other enables are 0. Next state is HALTED.
  4. branch_taken: all enables are 1, if_id_flush=1, id_ex_flush=1. Any load-use request in the same cycle is discarded.
  5. Load-use (either code = 011, state RUN): pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. Next state is LU_STALL.
  6. Fetch miss (~ihit): pc_en=0, if_id_en=1 with if_id_flush=1. All downstream enables are 1.
  7. Otherwise all enables are 1 and both flushes are 0.
- A code of 011 while in LU_STALL does not start a second stall; it is treated as none. LU_STALL returns to RUN on the next non-frozen cycle.
- Forward selects, per operand: 001→01, 010→10, 100→11, 000 and 011→00. Codes 101–111 are treated as 000.
- stall_cnt increments on every rising edge where nRST=1, halt=0 and pc_en=0. flush_cnt increments on every edge where if_id_flush=1. Both wrap modulo 2^CNT_W.

## Timing
- While nRST=0: state=RUN, halt=0, both counters=0, all enables and flushes forced 0, fwd selects=00.
- State, halt and counters update on the rising edge of CLK only.
- Load-use costs exactly 1 bubble cycle, plus any freeze cycles, before the dependent instruction leaves ID.
- halt rises 1 cycle after the non-frozen cycle in which halt_mem=1. It then stays 1 until reset.
- Reset asserted mid-stall: state goes immediately to RUN, and the stall is lost.
- A freeze and a branch in the same cycle: the freeze wins. The branch flush is applied on the first unfrozen cycle, because branch_taken is held by the frozen EX/MEM latch.

## Test plan
- Reset released, ihit=1, no hazards: all enables 1, flushes 0, fwd selects 00, counters stay 0 over 10 cycles.
- src1=011 for 1 cycle, then src1=100: cycle 0 gives pc_en=0 and id_ex_flush=1; cycle 1 gives fwd_a_sel=11 with all enables 1; stall_cnt=1.
- dmem_req=1, dhit=0 for 3 cycles, then dhit=1: all enables 0 for 3 cycles, then resume; stall_cnt=3; state unchanged.
- branch_taken=1 together with src2=011: both flushes 1, pc_en=1, no transition to LU_STALL; flush_cnt=1.
- halt_mem=1: that cycle ex_mem_en=1, mem_wb_en=1, pc_en=0; next cycle halt=1 and all enables 0; stall_cnt frozen afterwards.
- CNT_W=4, ihit=0 for 17 cycles: stall_cnt=1 and flush_cnt=1 after wrap. nRST pulsed low mid-run: counters read 0 at once.
